// File: rtl/conv_window_mac.sv
// Sliding-window multiply-accumulate over an external image/weight memory.
// Handles one window origin at a time; the result is held until the consumer accepts it.
module conv_window_mac #(
    parameter int N_C     = 5,
    parameter int N_R     = 3,
    parameter int COL_FIL = 2,
    parameter int ROW_FIL = 2,
    parameter int DW      = 8,
    parameter int AW      = 8,
    parameter int ACCW    = 20
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            win_valid,
    output logic            win_ready,
    input  logic [3:0]      win_i,
    input  logic [3:0]      win_j,
    output logic            img_rd,
    output logic [AW-1:0]   img_addr,
    input  logic [DW-1:0]   img_data,
    output logic [3:0]      w_addr,
    input  logic [DW-1:0]   w_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] acc_out,
    output logic            out_last,
    output logic            out_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, OUT} state_t;

    state_t          state_q, state_d;
    logic            win_ready_q, win_ready_d;
    logic [3:0]      i_q, i_d, j_q, j_d;
    logic [3:0]      r_q, r_d, c_q, c_d;
    logic            err_q, err_d;
    logic            rd_dly_q, rd_dly_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [AW-1:0]   addr_hold_q, addr_hold_d;
    logic [3:0]      w_hold_q, w_hold_d;

    logic [AW-1:0]   addr_cur;
    logic [3:0]      w_cur;
    logic [2*DW:0]   pix_ext, wt_ext, prod;
    logic [ACCW-1:0] prod_ext;
    logic            out_of_range, last_rd, col_wrap, is_last;

    // Address generation for the read currently being issued
    always_comb begin
        addr_cur = AW'((32'(i_q) + 32'(r_q)) * 32'(N_C) + 32'(j_q) + 32'(c_q));
        w_cur    = 4'(32'(r_q) * 32'(COL_FIL) + 32'(c_q));
    end

    // Unsigned pixel times signed weight, done as a (2*DW+1)-bit two's complement product
    always_comb begin
        pix_ext  = {{DW{1'b0}}, 1'b0, img_data};
        wt_ext   = {{(DW+1){w_data[DW-1]}}, w_data};
        prod     = pix_ext * wt_ext;
        prod_ext = {{(ACCW-2*DW-1){prod[2*DW]}}, prod};
    end

    always_comb begin
        out_of_range = (int'(win_i) > N_R - ROW_FIL) || (int'(win_j) > N_C - COL_FIL);
        col_wrap     = (c_q == 4'(COL_FIL - 1));
        last_rd      = col_wrap && (r_q == 4'(ROW_FIL - 1));
        is_last      = !err_q && (int'(i_q) == N_R - ROW_FIL) && (int'(j_q) == N_C - COL_FIL);
    end

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        r_d         = r_q;
        c_d         = c_q;
        err_d       = err_q;
        addr_hold_d = addr_hold_q;
        w_hold_d    = w_hold_q;
        rd_dly_d    = (state_q == FETCH);
        acc_d       = rd_dly_q ? acc_q + prod_ext : acc_q;

        case (state_q)
            IDLE: begin
                if (win_valid && win_ready_q) begin
                    i_d     = win_i;
                    j_d     = win_j;
                    r_d     = '0;
                    c_d     = '0;
                    acc_d   = '0;
                    err_d   = out_of_range;
                    state_d = out_of_range ? OUT : FETCH;
                end
            end
            FETCH: begin
                addr_hold_d = addr_cur;
                w_hold_d    = w_cur;
                if (last_rd) begin
                    state_d = DRAIN;
                end else if (col_wrap) begin
                    c_d = '0;
                    r_d = r_q + 4'd1;
                end else begin
                    c_d = c_q + 4'd1;
                end
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered so that ready stays low while reset is held and rises on the first edge after
        win_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            win_ready_q <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            err_q       <= 1'b0;
            rd_dly_q    <= 1'b0;
            acc_q       <= '0;
            addr_hold_q <= '0;
            w_hold_q    <= '0;
        end else begin
            state_q     <= state_d;
            win_ready_q <= win_ready_d;
            i_q         <= i_d;
            j_q         <= j_d;
            r_q         <= r_d;
            c_q         <= c_d;
            err_q       <= err_d;
            rd_dly_q    <= rd_dly_d;
            acc_q       <= acc_d;
            addr_hold_q <= addr_hold_d;
            w_hold_q    <= w_hold_d;
        end
    end

    always_comb begin
        win_ready = win_ready_q;
        img_rd    = (state_q == FETCH);
        img_addr  = img_rd ? addr_cur : addr_hold_q;
        w_addr    = img_rd ? w_cur : w_hold_q;
        out_valid = (state_q == OUT);
        acc_out   = out_valid ? acc_q : '0;
        out_last  = out_valid && is_last;
        out_err   = out_valid && err_q;
    end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac: a window-level reference model checked every cycle,
// plus hand-computed results for the canonical windows.
module tb_conv_window_mac;

    localparam int N_C = 5, N_R = 3, COL_FIL = 2, ROW_FIL = 2;
    localparam int DW = 8, AW = 8, ACCW = 20;
    localparam int K = ROW_FIL * COL_FIL;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            win_valid = 1'b0;
    logic            win_ready;
    logic [3:0]      win_i = '0;
    logic [3:0]      win_j = '0;
    logic            img_rd;
    logic [AW-1:0]   img_addr;
    logic [DW-1:0]   img_data = '0;
    logic [3:0]      w_addr;
    logic [DW-1:0]   w_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [ACCW-1:0] acc_out;
    logic            out_last;
    logic            out_err;

    int passed = 0;
    int total  = 0;

    logic [7:0] img_mem [256];
    logic [7:0] w_mem   [16];

    always #5 clk = ~clk;

    conv_window_mac #(
        .N_C(N_C), .N_R(N_R), .COL_FIL(COL_FIL), .ROW_FIL(ROW_FIL),
        .DW(DW), .AW(AW), .ACCW(ACCW)
    ) dut (
        .clk(clk), .rst(rst),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_i(win_i), .win_j(win_j),
        .img_rd(img_rd), .img_addr(img_addr), .img_data(img_data),
        .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .out_last(out_last), .out_err(out_err)
    );

    // Synchronous memories: data appears the cycle after a read strobe
    always @(posedge clk) begin
        if (img_rd) begin
            img_data <= img_mem[img_addr];
            w_data   <= w_mem[w_addr];
        end
    end

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [ACCW-1:0] window_sum(input int i, input int j);
        int s = 0;
        for (int r = 0; r < ROW_FIL; r++)
            for (int c = 0; c < COL_FIL; c++)
                s += int'(img_mem[(i + r) * N_C + j + c]) * int'($signed(w_mem[r * COL_FIL + c]));
        return ACCW'(s);
    endfunction

    // Window-level model: mode 0 = just out of reset, 1 = ready, 2 = window in flight (m_t cycles since accept)
    int              m_mode = 0;
    int              m_t = 0;
    int              m_i = 0, m_j = 0;
    bit              m_err = 1'b0, m_last = 1'b0;
    logic [ACCW-1:0] m_acc = '0;
    logic [AW-1:0]   m_addr_last = '0;
    logic [3:0]      m_w_last = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0;
            m_t    = 0;
        end else begin
            case (m_mode)
                0: m_mode = 1;
                1: if (win_valid) begin
                    m_i    = int'(win_i);
                    m_j    = int'(win_j);
                    m_err  = (m_i > N_R - ROW_FIL) || (m_j > N_C - COL_FIL);
                    m_last = !m_err && m_i == N_R - ROW_FIL && m_j == N_C - COL_FIL;
                    m_acc  = m_err ? '0 : window_sum(m_i, m_j);
                    m_t    = 1;
                    m_mode = 2;
                end
                default: begin
                    if (m_t >= (m_err ? 1 : K + 2) && out_ready) begin
                        m_mode = 1;
                        m_t    = 0;
                    end else begin
                        m_t++;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        int  r, c;
        bit  exp_rd, exp_valid;
        if (!rst) begin
            m_addr_last = '0;
            m_w_last    = '0;
            chk("rst_win_ready", win_ready, 0);
            chk("rst_img_rd",    img_rd,    0);
            chk("rst_img_addr",  img_addr,  0);
            chk("rst_w_addr",    w_addr,    0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_acc_out",   acc_out,   0);
            chk("rst_out_last",  out_last,  0);
            chk("rst_out_err",   out_err,   0);
        end else begin
            exp_rd = (m_mode == 2) && !m_err && m_t >= 1 && m_t <= K;
            if (exp_rd) begin
                r = (m_t - 1) / COL_FIL;
                c = (m_t - 1) % COL_FIL;
                m_addr_last = AW'((m_i + r) * N_C + m_j + c);
                m_w_last    = 4'(r * COL_FIL + c);
            end
            exp_valid = (m_mode == 2) && m_t >= (m_err ? 1 : K + 2);
            chk("win_ready", win_ready, m_mode == 1);
            chk("img_rd",    img_rd,    exp_rd);
            chk("img_addr",  img_addr,  m_addr_last);
            chk("w_addr",    w_addr,    m_w_last);
            chk("out_valid", out_valid, exp_valid);
            if (exp_valid) begin
                chk("acc_out",  acc_out,  m_acc);
                chk("out_last", out_last, m_last);
                chk("out_err",  out_err,  m_err);
            end
        end
    end

    // Offers one origin, waits for the result, holds it `hold` cycles, then accepts it
    task automatic run_window(input int i, input int j, input int hold,
                              output logic [ACCW-1:0] acc, output logic last,
                              output logic err, output int lat);
        int n = 0;
        acc = '0; last = 1'b0; err = 1'b0; lat = 0;
        while (!win_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!win_ready) begin
            chk("ready_wait", win_ready, 1);
            return;
        end
        win_i = 4'(i); win_j = 4'(j); win_valid = 1'b1;
        @(posedge clk); #1 win_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("out_valid_wait", out_valid, 1);
        acc  = acc_out;
        last = out_last;
        err  = out_err;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
    endtask

    task automatic load_ramp();
        for (int a = 0; a < 256; a++) img_mem[a] = (a < N_R * N_C) ? 8'(a) : 8'd0;
        for (int a = 0; a < 16; a++) w_mem[a] = (a < K) ? 8'(a + 1) : 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ACCW-1:0] acc;
        logic            last, err;
        int              lat;

        load_ramp();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", win_ready, 1);

        run_window(0, 0, 0, acc, last, err, lat);
        chk("w00_acc", acc, 41);
        chk("w00_last", last, 0);
        chk("w00_lat", lat, 6);

        run_window(1, 3, 5, acc, last, err, lat);
        chk("w13_acc", acc, 121);
        chk("w13_last", last, 1);
        chk("w13_err", err, 0);

        run_window(0, 3, 0, acc, last, err, lat);
        chk("w03_acc", acc, 71);
        chk("w03_last", last, 0);

        run_window(2, 0, 0, acc, last, err, lat);
        chk("w20_err", err, 1);
        chk("w20_acc", acc, 0);
        chk("w20_lat", lat, 1);

        run_window(1, 4, 2, acc, last, err, lat);
        chk("w14_err", err, 1);
        chk("w14_last", last, 0);

        for (int a = 0; a < N_R * N_C; a++) img_mem[a] = 8'd255;
        for (int a = 0; a < K; a++) w_mem[a] = 8'h80;
        run_window(0, 0, 1, acc, last, err, lat);
        chk("neg_acc", $signed(acc), -130560);

        load_ramp();
        win_i = '0; win_j = '0; win_valid = 1'b1;
        @(posedge clk); #1 win_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("abort_img_rd", img_rd, 0);
        chk("abort_img_addr", img_addr, 0);
        chk("abort_w_addr", w_addr, 0);
        chk("abort_win_ready", win_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        run_window(0, 0, 0, acc, last, err, lat);
        chk("post_rst_acc", acc, 41);
        chk("post_rst_lat", lat, 6);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
- N_C, 5: image columns
- N_R, 3: image rows
- COL_FIL, 2: filter columns
- ROW_FIL, 2: filter rows
- DW, 8: pixel/weight width
- AW, 8: image address width
- ACCW, 20: accumulator width
REQ-002 SHALL have ports (name, direction, width, meaning), one per line; clock and reset first:
- clk, input, 1: single clock, rising edge
- rst, input, 1: asynchronous, active-low reset
- win_valid, input, 1: window origin valid
- win_ready, output, 1: block can accept an origin
- win_i, input, 4: window origin row
- win_j, input, 4: window origin column
- img_rd, output, 1: image memory read strobe
- img_addr, output, AW: image address
- img_data, input, DW: unsigned pixel, valid 1 cycle after img_rd
- w_addr, output, 4: kernel weight address
- w_data, input, DW: signed weight, valid 1 cycle after img_rd
- out_valid, output, 1: result valid
- out_ready, input, 1: downstream accepts result
- acc_out, output, ACCW: signed window sum
- out_last, output, 1: result belongs to the final window
- out_err, output, 1: origin was out of range

Function
REQ-003 SHALL use one clock domain and SHALL be fully synchronous to clk, except for rst.
REQ-004 SHALL implement an FSM with states IDLE, FETCH, DRAIN, OUT.
REQ-005 SHALL drive win_ready=1 only in IDLE; an origin is accepted on a clk edge where win_valid && win_ready.
REQ-006 On accept, SHALL capture win_i/win_j, clear the accumulator and row/col counters r=c=0, and go to FETCH; if win_i>N_R-ROW_FIL or win_j>N_C-COL_FIL, SHALL instead set the err flag and go directly to OUT.
REQ-007 In FETCH, every cycle SHALL:
- assert img_rd=1
- drive img_addr=(i+r)*N_C+(j+c), truncated to AW
- drive w_addr=r*COL_FIL+c
- advance c, wrapping to 0 at COL_FIL-1 and incrementing r
REQ-008 After issuing r=ROW_FIL-1, c=COL_FIL-1 (K=ROW_FIL*COL_FIL reads, no gaps), SHALL go to DRAIN for exactly 1 cycle, then to OUT.
REQ-009 On each cycle following an img_rd=1 cycle, SHALL add $signed({1'b0,img_data})*$signed(w_data) to the accumulator:
- the product is 2*DW+1 bits
- it is sign-extended to ACCW
- the sum wraps modulo 2^ACCW with no saturation
REQ-010 In OUT, SHALL hold out_valid=1 with acc_out, out_last and out_err stable until out_ready=1, then return to IDLE on that edge.
REQ-011 SHALL assert out_last=1 in OUT iff the captured i==N_R-ROW_FIL and j==N_C-COL_FIL and err=0.
REQ-012 SHALL assert out_err=1 with acc_out=0 and out_last=0 for an out-of-range origin, issuing no img_rd.
REQ-013 Latency SHALL be:
- accept at edge E0 gives FETCH cycles E0+1..E0+K, DRAIN at E0+K+1, out_valid=1 from E0+K+2
- K=4 by default
REQ-014 SHALL drive img_rd=0 outside FETCH; img_addr and w_addr hold their last value when idle.
REQ-015 SHALL start a new accept no earlier than the cycle after the OUT handshake, so at most one window is in flight.

Reset
REQ-016 While rst=0, SHALL asynchronously force:
- state=IDLE
- win_ready=0, img_rd=0, img_addr=0, w_addr=0
- acc_out=0, out_valid=0, out_last=0, out_err=0
- internal counters and err flag = 0
REQ-017 After rst rises, win_ready SHALL go to 1 on the first clk edge.
REQ-018 Reset asserted in FETCH, DRAIN or OUT SHALL abort the window with no out_valid pulse for it.

Verification
REQ-019 Image p(row,col)=row*5+col, weights {1,2,3,4}, origin (0,0) -> img_addr 0,1,5,6 on 4 consecutive cycles, acc_out=41, out_last=0, out_valid at E0+6.
REQ-020 Same memories, origin (1,3) -> img_addr 8,9,13,14, acc_out=121, out_last=1.
REQ-021 All pixels 255, all weights -128, origin (0,0) -> acc_out=-130560 (20-bit two's complement).
REQ-022 out_ready=0 for 5 cycles in OUT -> out_valid, acc_out and out_last stable, win_ready=0; out_ready=1 -> IDLE next cycle.
REQ-023 Origin (2,0) -> no img_rd, out_valid at E0+1 with out_err=1, acc_out=0.
REQ-024 rst=0 during the 2nd FETCH cycle -> all outputs 0 immediately; after release, origin (0,0) -> correct acc_out=41.
